// File: rtl/dsm_mod_param.sv
`timescale 1ns/1ps
// dsm_mod_param: parametrised first/second-order delta-sigma modulator producing a 1-bit density stream.
// Optional quantiser dither is compiled in when the macro DSM_DITHER_EN is defined.
module dsm_mod_param #(
    parameter int WIDTH = 16,
    parameter int ORDER = 2,
    parameter int GUARD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    ovf_clr,
    output logic                    quant_out,
    output logic                    out_valid,
    output logic                    ovf
);
    localparam int ACCW = WIDTH + GUARD;
    localparam int SUMW = ACCW + 2;

    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
        $error("dsm_mod_param: ORDER must be 1 or 2");
    end

    localparam logic signed [SUMW-1:0] ACC_MAX = {{3{1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] ACC_MIN = {{3{1'b1}}, {(ACCW-1){1'b0}}};
    localparam logic signed [SUMW-1:0] FS_POS  = {{(SUMW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SUMW-1:0] FS_NEG  = {{(SUMW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [ACCW-1:0] sat(input logic signed [SUMW-1:0] v);
        if (v > ACC_MAX)
            return ACC_MAX[ACCW-1:0];
        else if (v < ACC_MIN)
            return ACC_MIN[ACCW-1:0];
        else
            return v[ACCW-1:0];
    endfunction

    function automatic logic clips(input logic signed [SUMW-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    logic signed [ACCW-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                   quant_q, quant_d, valid_q, valid_d, ovf_q, ovf_d;
    logic signed [SUMW-1:0] x_s, fb_s, sum1, sum2, lvl, dith_s;
    logic                   clip1, clip2;

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; dither only touches the quantiser decision.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en)
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dith_s = SUMW'($signed({1'b0, lfsr_q[3:0]})) - SUMW'(8);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= lfsr_d;
    end
`else
    assign dith_s = '0;
`endif

    always_comb begin
        x_s     = SUMW'(data_in);
        fb_s    = quant_q ? FS_POS : FS_NEG;
        sum1    = SUMW'(i1_q) + x_s - fb_s;
        sum2    = SUMW'(i2_q) + SUMW'(i1_q) - fb_s;
        clip1   = clips(sum1);
        clip2   = (ORDER == 2) && clips(sum2);
        i1_d    = i1_q;
        i2_d    = i2_q;
        quant_d = quant_q;
        valid_d = en;
        ovf_d   = ovf_q;
        lvl     = '0;
        if (en) begin
            i1_d    = sat(sum1);
            i2_d    = (ORDER == 2) ? sat(sum2) : '0;
            lvl     = SUMW'((ORDER == 2) ? i2_d : i1_d) + dith_s;
            quant_d = (lvl >= 0);
        end
        // A clamp in this cycle outranks a simultaneous clear request.
        if (en && (clip1 || clip2))
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i1_q    <= '0;
            i2_q    <= '0;
            quant_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            quant_q <= quant_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quant_out = quant_q;
    assign out_valid = valid_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_dsm_mod_param.sv
`timescale 1ns/1ps
// tb_dsm_mod_param: directed bench for first- and second-order instances of dsm_mod_param
// (WIDTH=16, GUARD=4, default no-dither build).
module tb_dsm_mod_param;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               en = 1'b0;
    logic               ovf_clr = 1'b0;
    logic signed [15:0] din1 = '0;
    logic signed [15:0] din2 = '0;
    logic               q1, v1, o1, q2, v2, o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsm_mod_param #(.WIDTH(16), .ORDER(1), .GUARD(4)) u_o1 (
        .clk(clk), .reset(reset), .en(en), .data_in(din1), .ovf_clr(ovf_clr),
        .quant_out(q1), .out_valid(v1), .ovf(o1)
    );

    dsm_mod_param #(.WIDTH(16), .ORDER(2), .GUARD(4)) u_o2 (
        .clk(clk), .reset(reset), .en(en), .data_in(din2), .ovf_clr(ovf_clr),
        .quant_out(q2), .out_valid(v2), .ovf(o2)
    );

    typedef struct {
        logic               en;
        logic signed [15:0] d1;
        logic signed [15:0] d2;
        logic               clr;
        logic               q1;
        logic               q2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_row(input int i, input int e, input int d1, input int d2,
                           input int c, input int eq1, input int eq2);
        tbl[i].en  = e[0];
        tbl[i].d1  = 16'(d1);
        tbl[i].d2  = 16'(d2);
        tbl[i].clr = c[0];
        tbl[i].q1  = eq1[0];
        tbl[i].q2  = eq2[0];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q1"}, q1, 0);
        chk({tag, "_v1"}, v1, 0);
        chk({tag, "_o1"}, o1, 0);
        chk({tag, "_q2"}, q2, 0);
        chk({tag, "_v2"}, v2, 0);
        chk({tag, "_o2"}, o2, 0);
    endtask

    // Called 1 ns after a rising edge; reset lands mid-cycle so the check is purely asynchronous.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b0;
        en = 1'b0; ovf_clr = 1'b0; din1 = '0; din2 = '0;
        #1;
        chk_all_zero(tag);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            en = tbl[i].en; din1 = tbl[i].d1; din2 = tbl[i].d2; ovf_clr = tbl[i].clr;
            @(posedge clk); #1;
            chk($sformatf("%s_r%0d_q1", tag, i), q1, int'(tbl[i].q1));
            chk($sformatf("%s_r%0d_q2", tag, i), q2, int'(tbl[i].q2));
            chk($sformatf("%s_r%0d_v1", tag, i), v1, int'(tbl[i].en));
            chk($sformatf("%s_r%0d_v2", tag, i), v2, int'(tbl[i].en));
            chk($sformatf("%s_r%0d_ovf", tag, i), {30'd0, o1, o2}, 0);
        end
        en = 1'b0; ovf_clr = 1'b0;
    endtask

    // Counts ones over 1024 accepted samples; 'bad' collects valid/hold/ovf violations.
    task automatic density(input logic signed [15:0] a1, input logic signed [15:0] a2,
                           input bit toggle, output int n1, output int n2, output int bad);
        int acc;
        int cyc;
        logic pq1, pq2;
        n1 = 0; n2 = 0; bad = 0; acc = 0; cyc = 0;
        din1 = a1; din2 = a2; ovf_clr = 1'b0;
        while (acc < 1024) begin
            en = toggle ? (cyc % 2 == 0) : 1'b1;
            pq1 = q1; pq2 = q2;
            @(posedge clk); #1;
            cyc++;
            if (en) begin
                acc++;
                n1 += int'(q1);
                n2 += int'(q2);
                if (!v1 || !v2) bad++;
            end else begin
                if (v1 || v2 || q1 !== pq1 || q2 !== pq2) bad++;
            end
            if (o1 || o2) bad++;
        end
        en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n1, n2, bad;

        set_row(0,  1,      0, -8192, 0, 1, 1);
        set_row(1,  1,      0, -8192, 0, 1, 1);
        set_row(2,  1,      0, -8192, 0, 0, 0);
        set_row(3,  0,  12345, 12345, 0, 0, 0);
        set_row(4,  1,  16384, -8192, 0, 1, 0);
        set_row(5,  1,  16384, -8192, 1, 1, 0);
        set_row(6,  1,  16384, -8192, 0, 0, 0);
        set_row(7,  1, -16384, -8192, 0, 1, 1);
        set_row(8,  1, -16384, -8192, 0, 0, 1);
        set_row(9,  1, -32768, -8192, 0, 0, 1);
        set_row(10, 0,      0,     0, 0, 0, 1);
        set_row(11, 1,  32767, -8192, 0, 1, 0);

        // Reset held while inputs wiggle: outputs must stay at reset values.
        #3;
        chk_all_zero("rst_init");
        for (int k = 0; k < 3; k++) begin
            en = 1'b1; ovf_clr = $urandom_range(0, 1) == 1;
            din1 = 16'($urandom); din2 = 16'($urandom);
            @(posedge clk); #1;
            chk_all_zero($sformatf("rst_hold%0d", k));
        end
        en = 1'b0; ovf_clr = 1'b0;
        reset = 1'b1;

        run_table("tbl");

        apply_reset("rst_a");
        density(16'sd0, -16'sd8192, 1'b0, n1, n2, bad);
        chk_rng("dens_o1_zero", n1, 511, 513);
        chk_rng("dens_o2_m8192", n2, 382, 386);
        chk("dens_a_flags", bad, 0);

        apply_reset("rst_b");
        density(16'sd16384, -16'sd8192, 1'b1, n1, n2, bad);
        chk_rng("dens_o1_p16384", n1, 767, 769);
        chk_rng("dens_o2_toggle", n2, 382, 386);
        chk("dens_toggle_flags", bad, 0);

        apply_reset("rst_c");
        density(-16'sd16384, -16'sd8192, 1'b0, n1, n2, bad);
        chk_rng("dens_o1_m16384", n1, 255, 257);
        chk("dens_c_flags", bad, 0);

        // Full-scale drive into the second-order loop.
        apply_reset("rst_d");
        din1 = 16'sd32767; din2 = 16'sd32767; en = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        chk("sat_ovf2", o2, 1);
        chk("sat_ovf1", o1, 0);
        chk("sat_q2", q2, 1);
        chk("sat_i2_pinned", int'(u_o2.i2_q), 524287);
        chk("sat_i1_value", int'(u_o2.i1_q), 63536);

        ovf_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_vs_set", o2, 1);
        chk("clr_vs_set_i2", int'(u_o2.i2_q), 524287);

        en = 1'b0; din2 = '0;
        @(posedge clk); #1;
        chk("clr_idle", o2, 0);
        ovf_clr = 1'b0;
        @(posedge clk); #1;
        chk("clr_stays", o2, 0);
        chk("idle_q2_held", q2, 1);
        chk("idle_valid", v2, 0);

        // Saturate again, then reset mid-cycle with everything active.
        en = 1'b1; din2 = 16'sd32767;
        @(posedge clk); #1;
        chk("pre_rst_ovf", o2, 1);
        chk("pre_rst_valid", v2, 1);
        apply_reset("rst_mid");
        chk("rst_mid_i1", int'(u_o2.i1_q), 0);
        chk("rst_mid_i2", int'(u_o2.i2_q), 0);

        run_table("tbl2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
